// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// load_store_unit : one-at-a-time load/store bridge to a byte-addressable RAM.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'd1024,
  parameter logic [31:0] LIMIT_ADDR = 32'd1055,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_wr_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_wr_mode,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_en,
  output logic [1:0]  mem_rd_mode,
  input  logic [31:0] mem_rd_data
);

  localparam int               CNT_W    = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       r_state;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic        w_accept;
  logic        w_legal;
  logic        w_misaligned;
  logic        w_range_err;
  logic        w_err;
  logic [32:0] w_size;
  logic [32:0] w_end;
  logic [31:0] w_load_ext;
  logic        w_in_write;
  logic        w_in_read;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal = 1'b0;
    if (req_we) begin
      w_legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                 w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   w_size = 33'd1;
      2'b01:   w_size = 33'd2;
      default: w_size = 33'd4;
    endcase
  end

  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  // 33-bit end address so a word near 0xFFFFFFFF cannot wrap back into range
  assign w_end       = {1'b0, req_addr} + w_size - 33'd1;
  assign w_range_err = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) ||
                       (w_end > {1'b0, LIMIT_ADDR});
  assign w_err       = !w_legal || w_misaligned || w_range_err;

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{24{mem_rd_data[7]}},  mem_rd_data[7:0]};
      3'b001:  w_load_ext = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
      3'b100:  w_load_ext = {24'd0, mem_rd_data[7:0]};
      3'b101:  w_load_ext = {16'd0, mem_rd_data[15:0]};
      default: w_load_ext = mem_rd_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_cnt    <= '0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= '0;
            if (w_err) begin
              r_state <= S_RESP;
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end else if (req_we) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          r_state <= S_RESP;
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
        end
        S_READ: begin
          // read data is only trusted on the final READ cycle
          if (r_cnt == CNT_LAST) begin
            r_state <= S_RESP;
            r_rdata <= w_load_ext;
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_write = (r_state == S_WRITE);
  assign w_in_read  = (r_state == S_READ);

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;

  assign mem_wr_en   = w_in_write;
  assign mem_wr_addr = w_in_write ? r_addr        : 32'd0;
  assign mem_wr_data = w_in_write ? r_wdata       : 32'd0;
  assign mem_wr_mode = w_in_write ? r_funct3[1:0] : 2'd0;

  assign mem_rd_en   = w_in_read;
  assign mem_rd_addr = w_in_read ? r_addr        : 32'd0;
  assign mem_rd_mode = w_in_read ? r_funct3[1:0] : 2'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// tb_load_store_unit : three LSU instances (read latency 1, 0, 3) against a
// byte-array reference model. Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a         [NI];
  logic        req_valid_a   [NI];
  logic        req_we_a      [NI];
  logic [2:0]  req_funct3_a  [NI];
  logic [31:0] req_addr_a    [NI];
  logic [31:0] req_wdata_a   [NI];
  logic        req_ready_a   [NI];
  logic        resp_valid_a  [NI];
  logic [31:0] resp_rdata_a  [NI];
  logic        resp_err_a    [NI];
  logic [31:0] mem_wr_addr_a [NI];
  logic        mem_wr_en_a   [NI];
  logic [31:0] mem_wr_data_a [NI];
  logic [1:0]  mem_wr_mode_a [NI];
  logic [31:0] mem_rd_addr_a [NI];
  logic        mem_rd_en_a   [NI];
  logic [1:0]  mem_rd_mode_a [NI];
  logic [31:0] mem_rd_data_a [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_mem [NI][32];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    logic [7:0]  ram [32] = '{default: 8'h00};
    int          rd_run = 0;
    logic [31:0] junk = 32'h0;
    logic [4:0]  wi, ri;
    logic [31:0] w_rd;

    load_store_unit #(
      .BASE_ADDR (32'd1024),
      .LIMIT_ADDR(32'd1055),
      .RD_LATENCY(LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_a[g]),
      .req_valid  (req_valid_a[g]),
      .req_ready  (req_ready_a[g]),
      .req_we     (req_we_a[g]),
      .req_funct3 (req_funct3_a[g]),
      .req_addr   (req_addr_a[g]),
      .req_wdata  (req_wdata_a[g]),
      .resp_valid (resp_valid_a[g]),
      .resp_rdata (resp_rdata_a[g]),
      .resp_err   (resp_err_a[g]),
      .mem_wr_addr(mem_wr_addr_a[g]),
      .mem_wr_en  (mem_wr_en_a[g]),
      .mem_wr_data(mem_wr_data_a[g]),
      .mem_wr_mode(mem_wr_mode_a[g]),
      .mem_rd_addr(mem_rd_addr_a[g]),
      .mem_rd_en  (mem_rd_en_a[g]),
      .mem_rd_mode(mem_rd_mode_a[g]),
      .mem_rd_data(mem_rd_data_a[g])
    );

    assign wi = mem_wr_addr_a[g][4:0];
    assign ri = mem_rd_addr_a[g][4:0];

    // RAM model: data is valid only once LAT cycles of read enable have elapsed
    always @(posedge clk) begin
      junk <= $urandom;
      rd_run <= mem_rd_en_a[g] ? rd_run + 1 : 0;
      if (mem_wr_en_a[g]) begin
        ram[wi] <= mem_wr_data_a[g][7:0];
        if (mem_wr_mode_a[g] != 2'd0) ram[wi + 5'd1] <= mem_wr_data_a[g][15:8];
        if (mem_wr_mode_a[g] == 2'd2) begin
          ram[wi + 5'd2] <= mem_wr_data_a[g][23:16];
          ram[wi + 5'd3] <= mem_wr_data_a[g][31:24];
        end
      end
    end

    always_comb begin
      case (mem_rd_mode_a[g])
        2'd0:    w_rd = {junk[31:8], ram[ri]};
        2'd1:    w_rd = {junk[31:16], ram[ri + 5'd1], ram[ri]};
        default: w_rd = {ram[ri + 5'd3], ram[ri + 5'd2], ram[ri + 5'd1], ram[ri]};
      endcase
      if (rd_run < LAT) w_rd = junk;
    end

    assign mem_rd_data_a[g] = w_rd;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: legality, alignment and range from the access rules; memory as bytes.
  function automatic void model(input int k, input bit we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output bit err, output logic [31:0] rd);
    longint lo;
    int     size;
    int     idx;
    bit     legal;
    logic [31:0] w;
    lo    = longint'(a);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    err   = !legal || ((lo % size) != 0) || (lo < 1024) || (lo + size - 1 > 1055);
    rd    = 32'd0;
    if (!err) begin
      idx = int'(lo - 1024);
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[k][idx + i] = wd[8*i +: 8];
      end else begin
        w = 32'd0;
        for (int i = 0; i < size; i++) w[8*i +: 8] = ref_mem[k][idx + i];
        case (f3)
          3'd0:    rd = 32'($signed(w[7:0]));
          3'd1:    rd = 32'($signed(w[15:0]));
          default: rd = w;
        endcase
      end
    end
  endfunction

  task automatic do_txn(input int k, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          lat, exp_c, c, resp_c, wr_n, rd_n, first_c;
    bit          bad, got;
    logic [31:0] got_rd;
    logic        got_err;
    string       t;
    lat = lat_of(k);
    model(k, we, f3, a, wd, exp_err, exp_rd);
    exp_c = exp_err ? 1 : (we ? 2 : lat + 2);
    t = $sformatf("i%0d %s f3=%0d a=%08h", k, we ? "ST" : "LD", f3, a);
    check_eq({t, " ready"}, 32'(req_ready_a[k]), 32'd1);

    req_valid_a[k]  = 1'b1;
    req_we_a[k]     = we;
    req_funct3_a[k] = f3;
    req_addr_a[k]   = a;
    req_wdata_a[k]  = wd;
    @(posedge clk); #1;
    req_valid_a[k]  = 1'b0;
    req_we_a[k]     = 1'($urandom);
    req_funct3_a[k] = 3'($urandom);
    req_addr_a[k]   = $urandom;
    req_wdata_a[k]  = $urandom;

    c = 1; got = 0; resp_c = 0; wr_n = 0; rd_n = 0; first_c = 0; bad = 0;
    got_rd = 32'hFFFF_FFFF; got_err = 1'bx;
    while (!got && c <= 12) begin
      if (mem_wr_en_a[k]) begin
        if (first_c == 0) first_c = c;
        wr_n++;
        if (mem_wr_addr_a[k] !== a || mem_wr_data_a[k] !== wd || mem_wr_mode_a[k] !== f3[1:0]) bad = 1;
      end else if (mem_wr_addr_a[k] !== 32'd0 || mem_wr_data_a[k] !== 32'd0 || mem_wr_mode_a[k] !== 2'd0) begin
        bad = 1;
      end
      if (mem_rd_en_a[k]) begin
        if (first_c == 0) first_c = c;
        rd_n++;
        if (mem_rd_addr_a[k] !== a || mem_rd_mode_a[k] !== f3[1:0]) bad = 1;
      end else if (mem_rd_addr_a[k] !== 32'd0 || mem_rd_mode_a[k] !== 2'd0) begin
        bad = 1;
      end
      if (mem_wr_en_a[k] && mem_rd_en_a[k]) bad = 1;
      if (resp_valid_a[k] === 1'b1) begin
        got = 1; resp_c = c; got_rd = resp_rdata_a[k]; got_err = resp_err_a[k];
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end

    check_eq({t, " resp_cycle"}, 32'(resp_c), 32'(exp_c));
    check_eq({t, " err"}, 32'(got_err), 32'(exp_err));
    check_eq({t, " rdata"}, got_rd, exp_rd);
    check_eq({t, " wr_cycles"}, 32'(wr_n), (we && !exp_err) ? 32'd1 : 32'd0);
    check_eq({t, " rd_cycles"}, 32'(rd_n), (!we && !exp_err) ? 32'(lat + 1) : 32'd0);
    check_eq({t, " first_en_cycle"}, 32'(first_c), exp_err ? 32'd0 : 32'd1);
    check_eq({t, " port_values"}, 32'(bad), 32'd0);

    @(posedge clk); #1;
    check_eq({t, " idle_after"}, {30'd0, req_ready_a[k], resp_valid_a[k]}, 32'd2);
    check_eq({t, " rdata_hold"}, resp_rdata_a[k], exp_rd);
    check_eq({t, " err_hold"}, 32'(resp_err_a[k]), 32'(exp_err));
  endtask

  task automatic mid_read_reset(input int k);
    req_valid_a[k]  = 1'b1;
    req_we_a[k]     = 1'b0;
    req_funct3_a[k] = 3'b010;
    req_addr_a[k]   = 32'd1040;
    @(posedge clk); #1;
    req_valid_a[k]  = 1'b0;
    check_eq("rst rd_en first READ", 32'(mem_rd_en_a[k]), 32'd1);
    @(posedge clk); #1;
    check_eq("rst rd_en second READ", 32'(mem_rd_en_a[k]), 32'd1);
    rst_a[k] = 1'b1;
    #1;
    check_eq("rst rd_en drops", 32'(mem_rd_en_a[k]), 32'd0);
    check_eq("rst ready", 32'(req_ready_a[k]), 32'd1);
    check_eq("rst resp_valid", 32'(resp_valid_a[k]), 32'd0);
    @(posedge clk); #1;
    rst_a[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rst no response", 32'(resp_valid_a[k]), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("rst ready after", 32'(req_ready_a[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_a[k]        = 1'b1;
      req_valid_a[k]  = 1'b0;
      req_we_a[k]     = 1'b0;
      req_funct3_a[k] = 3'd0;
      req_addr_a[k]   = 32'd0;
      req_wdata_a[k]  = 32'd0;
      for (int b = 0; b < 32; b++) ref_mem[k][b] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst_a[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("i%0d reset ready", k), 32'(req_ready_a[k]), 32'd1);
      check_eq($sformatf("i%0d reset resp", k),
               {29'd0, resp_valid_a[k], resp_err_a[k], mem_wr_en_a[k] | mem_rd_en_a[k]}, 32'd0);
      check_eq($sformatf("i%0d reset rdata", k), resp_rdata_a[k], 32'd0);
      check_eq($sformatf("i%0d reset mem", k),
               mem_wr_addr_a[k] | mem_wr_data_a[k] | mem_rd_addr_a[k] |
               {28'd0, mem_wr_mode_a[k], mem_rd_mode_a[k]}, 32'd0);
    end

    // word round trip, byte and half merges into the word
    do_txn(0, 1, 3'b010, 32'd1024, 32'hDEADBEEF);
    do_txn(0, 0, 3'b010, 32'd1024, 32'd0);
    do_txn(0, 1, 3'b000, 32'd1029, 32'h00000080);
    do_txn(0, 0, 3'b000, 32'd1029, 32'd0);
    do_txn(0, 0, 3'b100, 32'd1029, 32'd0);
    do_txn(0, 0, 3'b010, 32'd1028, 32'd0);
    do_txn(0, 1, 3'b001, 32'd1030, 32'h00008001);
    do_txn(0, 0, 3'b001, 32'd1030, 32'd0);
    do_txn(0, 0, 3'b101, 32'd1030, 32'd0);
    do_txn(0, 0, 3'b010, 32'd1028, 32'd0);
    // errors: misaligned and illegal funct3
    do_txn(0, 0, 3'b010, 32'd1026, 32'd0);
    do_txn(0, 1, 3'b001, 32'd1027, 32'h1234);
    do_txn(0, 0, 3'b011, 32'd1024, 32'd0);
    do_txn(0, 1, 3'b100, 32'd1024, 32'h55);
    // range edges
    do_txn(0, 0, 3'b010, 32'd1052, 32'd0);
    do_txn(0, 0, 3'b010, 32'd1056, 32'd0);
    do_txn(0, 0, 3'b000, 32'd1023, 32'd0);
    do_txn(0, 0, 3'b010, 32'hFFFFFFFC, 32'd0);
    do_txn(0, 0, 3'b000, 32'd1055, 32'd0);
    do_txn(0, 1, 3'b010, 32'd1052, 32'hCAFEF00D);
    do_txn(0, 0, 3'b000, 32'd1055, 32'd0);

    // other read latencies
    for (int k = 1; k < NI; k++) begin
      do_txn(k, 1, 3'b010, 32'd1024, 32'h89ABCDEF);
      do_txn(k, 0, 3'b010, 32'd1024, 32'd0);
      do_txn(k, 0, 3'b000, 32'd1027, 32'd0);
      do_txn(k, 0, 3'b101, 32'd1026, 32'd0);
      do_txn(k, 0, 3'b010, 32'd1056, 32'd0);
    end

    mid_read_reset(0);
    do_txn(0, 1, 3'b010, 32'd1040, 32'h13579BDF);
    do_txn(0, 0, 3'b010, 32'd1040, 32'd0);

    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < ((k == 0) ? 80 : 30); n++) begin
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else                           a = 32'd1016 + 32'($urandom_range(0, 47));
        do_txn(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
